// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine
//   VGA timing generator with a fixed-priority rectangle sprite compositor.
//   Sprite fields are written into shadow registers. A commit request copies
//   the whole shadow set into the active set at the next frame boundary, so a
//   frame is never drawn from a half-updated sprite set.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   pixel_strobe   pixel enable; counters and video outputs advance only here
//   wr_en          shadow register write strobe
//   wr_sprite      target sprite index (indices >= NUM_SPRITES are ignored)
//   wr_field       0=x1 1=y1 2=x2 3=y2 4=color 5=enable 6=commit 7=reserved
//   wr_data        field data
//   h_sync/v_sync  registered sync outputs, asserted level SYNC_POL
//   r, g, b        registered pixel colour
//   frame_start    one-cycle pulse when the counters wrap to h=0, v=0
//   commit_pending commit requested but not yet applied
module vga_sprite_engine #(
  parameter int H_SYNC_START = 16,
  parameter int H_SYNC_END   = 112,
  parameter int H_DRAW_START = 160,
  parameter int H_TOTAL      = 800,
  parameter int V_SYNC_START = 10,
  parameter int V_SYNC_END   = 12,
  parameter int V_DRAW_START = 45,
  parameter int V_TOTAL      = 525,
  parameter bit SYNC_POL     = 1'b1,
  parameter int NUM_SPRITES  = 4,
  parameter int COLOR_W      = 1,
  parameter int BG_COLOR     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_strobe,
  input  logic               wr_en,
  input  logic [3:0]         wr_sprite,
  input  logic [2:0]         wr_field,
  input  logic [11:0]        wr_data,
  output logic               h_sync,
  output logic               v_sync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start,
  output logic               commit_pending
);

  localparam int CW = 3 * COLOR_W;

  logic [9:0] h_count_r;
  logic [9:0] v_count_r;

  // Shadow (CPU-visible) and active (displayed) sprite sets.
  logic [9:0]             shd_x1_r    [NUM_SPRITES];
  logic [9:0]             shd_x2_r    [NUM_SPRITES];
  logic [8:0]             shd_y1_r    [NUM_SPRITES];
  logic [8:0]             shd_y2_r    [NUM_SPRITES];
  logic [CW-1:0]          shd_color_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shd_en_r;
  logic [9:0]             act_x1_r    [NUM_SPRITES];
  logic [9:0]             act_x2_r    [NUM_SPRITES];
  logic [8:0]             act_y1_r    [NUM_SPRITES];
  logic [8:0]             act_y2_r    [NUM_SPRITES];
  logic [CW-1:0]          act_color_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_en_r;

  logic          h_end_s;
  logic          v_end_s;
  logic          boundary_s;
  logic          wr_ok_s;
  logic          commit_req_s;
  logic [9:0]    x_s;
  logic [8:0]    y_s;
  logic          visible_s;
  logic          hit_any_s;
  logic [CW-1:0] hit_color_s;
  logic [CW-1:0] pix_s;
  logic          hs_s;
  logic          vs_s;
  logic          unused_ok_s;

  // wr_data[11:10] carries no field.
  assign unused_ok_s = &{1'b0, wr_data[11:10]};

  // Counter wrap, frame boundary and write decode.
  always_comb begin
    h_end_s      = (h_count_r == 10'(H_TOTAL - 1));
    v_end_s      = (v_count_r == 10'(V_TOTAL - 1));
    boundary_s   = pixel_strobe && h_end_s && v_end_s;
    wr_ok_s      = wr_en && ({1'b0, wr_sprite} < 5'(NUM_SPRITES)) && (wr_field <= 3'd5);
    commit_req_s = wr_en && (wr_field == 3'd6);
  end

  // Pixel colour and sync levels for the current (pre-increment) counters.
  always_comb begin
    // Wrapped values during blanking are harmless: visible_s gates the colour.
    x_s         = h_count_r - 10'(H_DRAW_START);
    y_s         = 9'(v_count_r - 10'(V_DRAW_START));
    visible_s   = (h_count_r >= 10'(H_DRAW_START)) && (v_count_r >= 10'(V_DRAW_START));
    hit_any_s   = 1'b0;
    hit_color_s = '0;
    // Walk from lowest to highest priority so the lowest hit index wins.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (act_en_r[i] && (x_s >= act_x1_r[i]) && (x_s <= act_x2_r[i]) &&
          (y_s >= act_y1_r[i]) && (y_s <= act_y2_r[i])) begin
        hit_any_s   = 1'b1;
        hit_color_s = act_color_r[i];
      end else begin
        hit_any_s   = hit_any_s;
        hit_color_s = hit_color_s;
      end
    end
    if (!visible_s) begin
      pix_s = '0;
    end else if (!hit_any_s) begin
      pix_s = CW'(BG_COLOR);
    end else begin
      pix_s = hit_color_s;
    end
    hs_s = (h_count_r >= 10'(H_SYNC_START)) && (h_count_r < 10'(H_SYNC_END));
    vs_s = (v_count_r >= 10'(V_SYNC_START)) && (v_count_r < 10'(V_SYNC_END));
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_r <= 10'd0;
      v_count_r <= 10'd0;
    end else if (pixel_strobe) begin
      if (h_end_s) begin
        h_count_r <= 10'd0;
        v_count_r <= v_end_s ? 10'd0 : v_count_r + 10'd1;
      end else begin
        h_count_r <= h_count_r + 10'd1;
      end
    end
  end

  // Registered video outputs, loaded on strobe cycles only.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      {r, g, b}   <= '0;
      frame_start <= 1'b0;
    end else if (pixel_strobe) begin
      h_sync      <= hs_s ? SYNC_POL : ~SYNC_POL;
      v_sync      <= vs_s ? SYNC_POL : ~SYNC_POL;
      {r, g, b}   <= pix_s;
      frame_start <= h_end_s && v_end_s;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Shadow writes, commit tracking and the frame-boundary shadow-to-active copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shd_x1_r[i]    <= 10'd0;
        shd_x2_r[i]    <= 10'd0;
        shd_y1_r[i]    <= 9'd0;
        shd_y2_r[i]    <= 9'd0;
        shd_color_r[i] <= '0;
        act_x1_r[i]    <= 10'd0;
        act_x2_r[i]    <= 10'd0;
        act_y1_r[i]    <= 9'd0;
        act_y2_r[i]    <= 9'd0;
        act_color_r[i] <= '0;
      end
      shd_en_r       <= '0;
      act_en_r       <= '0;
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_ok_s && (wr_sprite == 4'(i))) begin
          case (wr_field)
            3'd0:    shd_x1_r[i]    <= wr_data[9:0];
            3'd1:    shd_y1_r[i]    <= wr_data[8:0];
            3'd2:    shd_x2_r[i]    <= wr_data[9:0];
            3'd3:    shd_y2_r[i]    <= wr_data[8:0];
            3'd4:    shd_color_r[i] <= wr_data[CW-1:0];
            3'd5:    shd_en_r[i]    <= wr_data[0];
            default: shd_en_r[i]    <= shd_en_r[i];
          endcase
        end
      end
      // Non-blocking copy reads pre-write shadow values in a same-cycle write.
      if (boundary_s && commit_pending) begin
        act_x1_r    <= shd_x1_r;
        act_x2_r    <= shd_x2_r;
        act_y1_r    <= shd_y1_r;
        act_y2_r    <= shd_y2_r;
        act_color_r <= shd_color_r;
        act_en_r    <= shd_en_r;
        // A commit arriving on the boundary itself waits for the next one.
        commit_pending <= commit_req_s;
      end else if (commit_req_s) begin
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine
//   Directed bench for vga_sprite_engine. Horizontal timing uses the default
//   parameters; the frame is shortened to 10 lines (v_sync on lines 2..3,
//   visible lines 4..9) so a frame is 8000 strobes. BG_COLOR is 3'b001.
//   A small position model (mh, mv) follows the counters from the driven
//   reset/strobe inputs; video outputs lag it by one strobe.
module tb_vga_sprite_engine;

  logic        clk;
  logic        reset;
  logic        pixel_strobe;
  logic        wr_en;
  logic [3:0]  wr_sprite;
  logic [2:0]  wr_field;
  logic [11:0] wr_data;
  logic        h_sync;
  logic        v_sync;
  logic        r;
  logic        g;
  logic        b;
  logic        frame_start;
  logic        commit_pending;

  int n_checks = 0;
  int n_fail   = 0;
  int mh = 0;
  int mv = 0;
  int t  = 0;

  vga_sprite_engine #(
    .H_SYNC_START(16), .H_SYNC_END(112), .H_DRAW_START(160), .H_TOTAL(800),
    .V_SYNC_START(2), .V_SYNC_END(4), .V_DRAW_START(4), .V_TOTAL(10),
    .SYNC_POL(1'b1), .NUM_SPRITES(4), .COLOR_W(1), .BG_COLOR(1)
  ) dut (
    .clk(clk), .reset(reset), .pixel_strobe(pixel_strobe),
    .wr_en(wr_en), .wr_sprite(wr_sprite), .wr_field(wr_field), .wr_data(wr_data),
    .h_sync(h_sync), .v_sync(v_sync), .r(r), .g(g), .b(b),
    .frame_start(frame_start), .commit_pending(commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the model follows the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mh = 0; mv = 0; t = 0;
    end else if (pixel_strobe) begin
      t++;
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 9) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic [2:0] f, input logic [11:0] d);
    wr_en = 1'b1; wr_sprite = s; wr_field = f; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 20000) begin tick(); n++; end
    check("run_to_bound", 32'(mh == h && mv == v), 32'd1);
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (t < target && n < 20000) begin tick(); n++; end
    check("run_until_bound", 32'(t == target), 32'd1);
  endtask

  initial begin
    int first_rise, run_len, first_run, hs_cnt, vs_cnt, fs_cnt, fs_t;
    int r_cnt, first_r, c3_cnt;
    logic exp_hs;

    reset = 1'b1; pixel_strobe = 1'b1; wr_en = 1'b0;
    wr_sprite = 4'd0; wr_field = 3'd0; wr_data = 12'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    check("rst_h_count", 32'(dut.h_count_r), 32'd0);
    check("rst_v_count", 32'(dut.v_count_r), 32'd0);
    check("rst_h_sync", 32'(h_sync), 32'd0);
    check("rst_v_sync", 32'(v_sync), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_commit_pending", 32'(commit_pending), 32'd0);

    // Timing over one full frame with strobe every cycle.
    first_rise = -1; run_len = 0; first_run = -1;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_t = -1;
    for (int k = 0; k < 8000; k++) begin
      tick();
      if (h_sync) begin
        hs_cnt++;
        if (first_rise < 0) first_rise = t;
        if (first_run < 0) run_len++;
      end else if (first_rise >= 0 && first_run < 0) begin
        first_run = run_len;
      end
      if (v_sync) vs_cnt++;
      if (frame_start) begin fs_cnt++; fs_t = t; end
    end
    check("hsync_first_rise", 32'(first_rise), 32'd17);
    check("hsync_run_len", 32'(first_run), 32'd96);
    check("hsync_per_frame", 32'(hs_cnt), 32'd960);
    check("vsync_per_frame", 32'(vs_cnt), 32'd1600);
    check("frame_start_count", 32'(fs_cnt), 32'd1);
    check("frame_start_time", 32'(fs_t), 32'd8000);

    // Commit mid-frame: sprite0 x 10..19, y 5, red.
    wr(4'd0, 3'd0, 12'd10);
    check("frame_start_one_cycle", 32'(frame_start), 32'd0);
    wr(4'd0, 3'd2, 12'd19);
    wr(4'd0, 3'd1, 12'd5);
    wr(4'd0, 3'd3, 12'd5);
    wr(4'd0, 3'd4, 12'h004);
    wr(4'd0, 3'd5, 12'd1);
    wr(4'd0, 3'd6, 12'd0);
    check("commit_pending_set", 32'(commit_pending), 32'd1);
    r_cnt = 0;
    while (t < 16000) begin
      tick();
      if (r) r_cnt++;
      if (t == 15999) check("commit_pending_hold", 32'(commit_pending), 32'd1);
    end
    check("no_red_before_boundary", 32'(r_cnt), 32'd0);
    check("commit_pending_cleared", 32'(commit_pending), 32'd0);
    check("frame_start_frame2", 32'(frame_start), 32'd1);

    r_cnt = 0; first_r = -1;
    while (t < 23600) begin
      tick();
      if (r) begin r_cnt++; if (first_r < 0) first_r = t; end
    end
    check("red_pixel_count", 32'(r_cnt), 32'd10);
    check("red_first_time", 32'(first_r), 32'd23371);

    // Priority: sprite0 x 0..99 red over sprite1 x 50..149 green, full height.
    wr(4'd0, 3'd0, 12'd0);
    wr(4'd0, 3'd2, 12'd99);
    wr(4'd0, 3'd1, 12'd0);
    wr(4'd0, 3'd3, 12'd479);
    wr(4'd1, 3'd0, 12'd50);
    wr(4'd1, 3'd2, 12'd149);
    wr(4'd1, 3'd1, 12'd0);
    wr(4'd1, 3'd3, 12'd479);
    wr(4'd1, 3'd4, 12'h002);
    wr(4'd1, 3'd5, 12'd1);
    wr(4'd0, 3'd6, 12'd0);
    run_until(24000);
    run_to(221, 1); check("vblank_black", 32'({r, g, b}), 32'd0);
    run_to(221, 5); check("x60_red", 32'({r, g, b}), 32'd4);
    run_to(281, 5); check("x120_green", 32'({r, g, b}), 32'd2);
    run_to(361, 5); check("x200_bg", 32'({r, g, b}), 32'd1);
    run_to(1, 6);   check("hblank_black", 32'({r, g, b}), 32'd0);
    run_to(161, 6); check("x0_red", 32'({r, g, b}), 32'd4);
    run_to(310, 6); check("x149_green", 32'({r, g, b}), 32'd2);
    run_to(311, 6); check("x150_bg", 32'({r, g, b}), 32'd1);
    run_to(0, 7);   check("x639_bg", 32'({r, g, b}), 32'd1);

    // Boundary race: sprite2 x 300..309 on y 0, colour 011, committed;
    // x1 rewritten to 305 on the boundary cycle itself.
    wr(4'd2, 3'd0, 12'd300);
    wr(4'd2, 3'd2, 12'd309);
    wr(4'd2, 3'd1, 12'd0);
    wr(4'd2, 3'd3, 12'd0);
    wr(4'd2, 3'd4, 12'h003);
    wr(4'd2, 3'd5, 12'd1);
    wr(4'd0, 3'd6, 12'd0);
    check("race_pending_set", 32'(commit_pending), 32'd1);
    run_to(799, 9);
    wr(4'd2, 3'd0, 12'd305);
    check("race_pending_cleared", 32'(commit_pending), 32'd0);
    check("race_frame_start", 32'(frame_start), 32'd1);
    c3_cnt = 0;
    while (t < 36000) begin tick(); if ({r, g, b} == 3'b011) c3_cnt++; end
    check("race_old_x1_width", 32'(c3_cnt), 32'd10);
    wr(4'd0, 3'd6, 12'd0);
    run_to(799, 9);
    wr(4'd1, 3'd6, 12'hfff);
    check("boundary_commit_stays", 32'(commit_pending), 32'd1);
    c3_cnt = 0;
    while (t < 44000) begin tick(); if ({r, g, b} == 3'b011) c3_cnt++; end
    check("race_new_x1_width", 32'(c3_cnt), 32'd5);

    // Invalid writes followed by a commit must leave the display unchanged.
    wr(4'd4, 3'd5, 12'd0);
    wr(4'd4, 3'd0, 12'd700);
    wr(4'd0, 3'd7, 12'd0);
    wr(4'd2, 3'd7, 12'd0);
    wr(4'd0, 3'd6, 12'd0);
    check("invalid_pending", 32'(commit_pending), 32'd1);
    run_until(48000);
    check("invalid_pending_cleared", 32'(commit_pending), 32'd0);
    c3_cnt = 0;
    while (t < 51700) begin tick(); if ({r, g, b} == 3'b011) c3_cnt++; end
    check("invalid_sprite2_width", 32'(c3_cnt), 32'd5);
    run_to(221, 5); check("invalid_x60_red", 32'({r, g, b}), 32'd4);
    run_to(281, 5); check("invalid_x120_green", 32'({r, g, b}), 32'd2);

    // Strobe every second cycle: outputs and counters hold between strobes.
    run_to(10, 6);
    for (int k = 0; k < 60; k++) begin
      pixel_strobe = 1'b1;
      tick();
      exp_hs = ((mh - 1) >= 16) && ((mh - 1) < 112);
      check("half_hsync_strobe", 32'(h_sync), 32'(exp_hs));
      check("half_hcount_strobe", 32'(dut.h_count_r), 32'(mh));
      pixel_strobe = 1'b0;
      tick();
      check("half_hsync_hold", 32'(h_sync), 32'(exp_hs));
      check("half_hcount_hold", 32'(dut.h_count_r), 32'(mh));
    end
    pixel_strobe = 1'b1;

    // Reset mid-frame with a commit pending and a write in the reset cycle.
    wr(4'd0, 3'd6, 12'd0);
    check("pre_reset_pending", 32'(commit_pending), 32'd1);
    reset = 1'b1;
    wr(4'd3, 3'd5, 12'd1);
    reset = 1'b0;
    check("mid_rst_h_count", 32'(dut.h_count_r), 32'd0);
    check("mid_rst_v_count", 32'(dut.v_count_r), 32'd0);
    check("mid_rst_pending", 32'(commit_pending), 32'd0);
    check("mid_rst_h_sync", 32'(h_sync), 32'd0);
    check("mid_rst_v_sync", 32'(v_sync), 32'd0);
    check("mid_rst_rgb", 32'({r, g, b}), 32'd0);
    check("mid_rst_frame_start", 32'(frame_start), 32'd0);
    check("mid_rst_act_en", 32'(dut.act_en_r), 32'd0);
    check("mid_rst_shd_en", 32'(dut.shd_en_r), 32'd0);
    tick();
    check("post_rst_h_count", 32'(dut.h_count_r), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
Parametrised VGA timing generator and multi-sprite rectangle renderer with double-buffered sprite registers. Drives h_sync/v_sync and an RGB pixel stream. Up to NUM_SPRITES filled rectangles are composited with fixed priority over a background colour. Sprite writes land in shadow registers and become visible only at a frame boundary after an explicit commit, so the screen never tears.

Parameters:
H_SYNC_START, 16, first h_count with h_sync asserted
H_SYNC_END, 112, first h_count with h_sync deasserted
H_DRAW_START, 160, first visible h_count
H_TOTAL, 800, pixels per line; h_count wraps at H_TOTAL-1
V_SYNC_START, 10, first v_count with v_sync asserted
V_SYNC_END, 12, first v_count with v_sync deasserted
V_DRAW_START, 45, first visible line
V_TOTAL, 525, lines per frame
SYNC_POL, 1, asserted level of h_sync/v_sync
NUM_SPRITES, 4, sprite count (1..16); index 0 = highest priority
COLOR_W, 1, bits per colour channel (1..4)
BG_COLOR, 0, 3*COLOR_W-bit background colour {r,g,b} for visible pixels with no sprite hit

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_strobe  in  1  one-cycle pixel enable; all timing advances only on strobe cycles
wr_en  in  1  shadow register write strobe
wr_sprite  in  4  target sprite index
wr_field  in  3  0=x1, 1=y1, 2=x2, 3=y2, 4=color, 5=enable, 6=commit, 7=reserved
wr_data  in  12  field data: x uses [9:0], y uses [8:0], color uses [3*COLOR_W-1:0], enable uses [0]
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
r, g, b  out  COLOR_W each  pixel colour
frame_start  out  1  one-cycle pulse on the strobe cycle that wraps to h=0, v=0
commit_pending  out  1  commit requested, not yet applied

Behaviour:
- Counters: 10-bit h_count/v_count. On a strobe cycle, h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps at V_TOTAL-1. No change on non-strobe cycles.
- Visible region: h_count in [H_DRAW_START, H_TOTAL) and v_count in [V_DRAW_START, V_TOTAL). x = h_count-H_DRAW_START, y = v_count-V_DRAW_START.
- Hit for sprite i: active enable=1 and x1<=x<=x2 and y1<=y<=y2 (unsigned, inclusive). x1>x2 or y1>y2 gives no hit.
- Colour selection: blank → all 0. Visible with no hit → BG_COLOR. Otherwise → colour of the lowest-index hit sprite.
- Output latency: h_sync, v_sync, r, g, b and frame_start are registered. They are loaded only on strobe cycles, from the pre-increment counter values, so outputs lag counters by exactly one strobe. They hold between strobes. frame_start is high only in the cycle it is loaded.
- Shadow writes: when wr_en=1, wr_sprite<NUM_SPRITES and wr_field<=5, the field is written to shadow on the next clk regardless of pixel_strobe. Out-of-range sprite index or field 7 is ignored.
- Commit: wr_en with wr_field=6 sets commit_pending; wr_sprite and wr_data are ignored.
- Frame boundary: the strobe cycle with h_count=H_TOTAL-1 and v_count=V_TOTAL-1. If commit_pending=1 there, all active registers are loaded from shadow and commit_pending clears.
- Simultaneous events at the boundary:
  - A shadow write in the same cycle lands in shadow, but the copy uses pre-write shadow values.
  - A commit request in the same cycle keeps commit_pending=1, so it applies at the next boundary.
  - Repeated commits before a boundary coalesce into one.
- Reset (any time, including mid-line or mid-frame):
  - Counters return to 0.
  - h_sync/v_sync go to ~SYNC_POL; r, g, b = 0; frame_start = 0; commit_pending = 0.
  - All shadow and active fields = 0, so every sprite is disabled.
  - Writes in the reset cycle are discarded.
- Widths: y comparisons use 9 bits (y<480); x uses 10 bits. The blank flag gates colour, so the out-of-range x/y values computed in blanking never matter.

Test Plan:
- Timing, strobe every cycle, defaults: h_sync=1 for exactly 96 consecutive strobes starting one strobe after h_count=16. v_sync=1 for exactly 1600 strobes per frame. frame_start pulses every 420000 strobes.
- Commit and latency: write sprite0 x1=10, x2=19, y1=5, y2=5, color=3'b100, enable=1, then commit mid-frame. Rest of that frame: r=0 everywhere. Next frame: r=1 on exactly 10 pixels (h_count 170..179 at v_count 50, visible one strobe later). commit_pending clears at the boundary.
- Priority/background with BG_COLOR=3'b001: sprite0 (x 0..99, red) overlaps sprite1 (x 50..149, green), both y 0..479. Required colour: x=60 → 100, x=120 → 010, x=200 → 001, blanking → 000.
- Boundary race: issue a commit and an x1 write on the frame-boundary cycle. The copy uses the old x1 and commit_pending stays 1. The new x1 appears one frame later.
- Strobe gating / invalid writes: pixel_strobe every 2nd cycle gives outputs stable for 2 cycles each. A write to wr_sprite=NUM_SPRITES or wr_field=7, then commit, leaves the display unchanged.
- Reset mid-frame at v_count=200: the next cycle shows counters 0, all sprites disabled, commit_pending=0, and outputs at reset values.
